cdb_arb: RTL

Completion-bus arbiter for the 2-way out-of-order core. Collects completion requests from the functional units, grants up to four per cycle, and drives the four-slot CDB (`cdb_broadcast`, `cdb_pr_tag0..3`, `cdb_ar_tag0..3`). The CDB feeds the map table ready bits, the RS wakeup and the ROB. Requesters hold their request until granted; the broadcast is registered and appears one cycle after the grant.

---
 rtl/cdb_arb_if.sv | 48 ++++
 rtl/cdb_arb.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cdb_arb_if.sv
// ============================================================================
//  Module      : cdb_arb_if
//  Description : Functional-unit completion requests and four-slot CDB bundle
//                for the completion-bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CDB_WIDTH
`define CDB_WIDTH 3
`endif

interface cdb_arb_if #(
    parameter int NUM_FU = 6
) ();
    logic [NUM_FU-1:0]          fu_req;
    logic [7*NUM_FU-1:0]        fu_pr_tag;
    logic [5*NUM_FU-1:0]        fu_ar_tag;
    logic [NUM_FU-1:0]          fu_grant;

    logic [`CDB_WIDTH-1:0]      cdb_broadcast;
    logic [6:0]                 cdb_pr_tag0;
    logic [6:0]                 cdb_pr_tag1;
    logic [6:0]                 cdb_pr_tag2;
    logic [6:0]                 cdb_pr_tag3;
    logic [4:0]                 cdb_ar_tag0;
    logic [4:0]                 cdb_ar_tag1;
    logic [4:0]                 cdb_ar_tag2;
    logic [4:0]                 cdb_ar_tag3;

    // Arbiter side
    modport master (
        input  fu_req, fu_pr_tag, fu_ar_tag,
        output fu_grant, cdb_broadcast,
        output cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3,
        output cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3
    );

    // Functional units and CDB consumers
    modport slave (
        output fu_req, fu_pr_tag, fu_ar_tag,
        input  fu_grant, cdb_broadcast,
        input  cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3,
        input  cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3
    );
endinterface

`default_nettype wire

// File: rtl/cdb_arb.sv
// ============================================================================
//  Module      : cdb_arb
//  Description : Completion-bus arbiter, grants up to four FU completions per
//                cycle and drives the registered four-slot CDB.
//                Define CDB_ARB_RR_EN for round-robin scan; otherwise fixed
//                priority from FU 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CDB_WIDTH
`define CDB_WIDTH 3
`endif

module cdb_arb #(
    parameter int NUM_FU = 6
) (
    input  wire logic   clock,
    input  wire logic   reset,
    input  wire logic   rob_mispredict,
    cdb_arb_if.master   bus
);

    localparam int              NUM_CDB   = 4;
    localparam int              PTR_W     = $clog2(NUM_FU);
    localparam logic [PTR_W:0]  c_num_fu  = (PTR_W+1)'(NUM_FU);
    localparam logic [2:0]      c_num_cdb = 3'(NUM_CDB);

    logic [6:0]         w_fu_pr [NUM_FU];
    logic [4:0]         w_fu_ar [NUM_FU];

    logic [NUM_FU-1:0]  w_grant;
    logic [6:0]         w_pr [NUM_CDB];
    logic [4:0]         w_ar [NUM_CDB];
    logic [2:0]         w_cnt;
    logic [PTR_W-1:0]   w_start;
    logic [PTR_W:0]     w_sum;
    logic [PTR_W-1:0]   w_idx;
    logic               w_en;

    logic [`CDB_WIDTH-1:0] r_bcast;
    logic [6:0]         r_pr [NUM_CDB];
    logic [4:0]         r_ar [NUM_CDB];

    for (genvar g = 0; g < NUM_FU; g++) begin : g_unpack
        assign w_fu_pr[g] = bus.fu_pr_tag[7*g +: 7];
        assign w_fu_ar[g] = bus.fu_ar_tag[5*g +: 5];
    end

`ifdef CDB_ARB_RR_EN
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_last;

    assign w_start = r_rr_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_cnt != 3'd0) begin
            r_rr_ptr <= (w_last == PTR_W'(NUM_FU-1)) ? '0 : w_last + PTR_W'(1);
        end
    end
`else
    assign w_start = '0;
`endif

    // Grant is suppressed during reset and recovery, which also zeroes the
    // next broadcast and freezes the scan pointer.
    assign w_en = !reset && !rob_mispredict;

    always_comb begin
        w_grant = '0;
        w_cnt   = 3'd0;
        w_sum   = '0;
        w_idx   = '0;
        for (int s = 0; s < NUM_CDB; s++) begin
            w_pr[s] = '0;
            w_ar[s] = '0;
        end
`ifdef CDB_ARB_RR_EN
        w_last  = '0;
`endif
        for (int k = 0; k < NUM_FU; k++) begin
            w_sum = {1'b0, w_start} + (PTR_W+1)'(k);
            if (w_sum >= c_num_fu) begin
                w_sum = w_sum - c_num_fu;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (w_en && bus.fu_req[w_idx] && (w_cnt < c_num_cdb)) begin
                w_grant[w_idx]    = 1'b1;
                w_pr[w_cnt[1:0]]  = w_fu_pr[w_idx];
                w_ar[w_cnt[1:0]]  = w_fu_ar[w_idx];
                w_cnt             = w_cnt + 3'd1;
`ifdef CDB_ARB_RR_EN
                w_last            = w_idx;
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bcast <= '0;
            for (int s = 0; s < NUM_CDB; s++) begin
                r_pr[s] <= '0;
                r_ar[s] <= '0;
            end
        end else begin
            r_bcast <= (`CDB_WIDTH)'(w_cnt);
            for (int s = 0; s < NUM_CDB; s++) begin
                r_pr[s] <= w_pr[s];
                r_ar[s] <= w_ar[s];
            end
        end
    end

    assign bus.fu_grant      = w_grant;
    assign bus.cdb_broadcast = r_bcast;
    assign bus.cdb_pr_tag0   = r_pr[0];
    assign bus.cdb_pr_tag1   = r_pr[1];
    assign bus.cdb_pr_tag2   = r_pr[2];
    assign bus.cdb_pr_tag3   = r_pr[3];
    assign bus.cdb_ar_tag0   = r_ar[0];
    assign bus.cdb_ar_tag1   = r_ar[1];
    assign bus.cdb_ar_tag2   = r_ar[2];
    assign bus.cdb_ar_tag3   = r_ar[3];

endmodule

`default_nettype wire
